wq_drain_arbiter: RTL

- Consumer-side controller for the 40-entry wavefront instruction-queue pool.
- Each cycle it picks one wavefront whose queue is non-empty and eligible, using round-robin order.
- It drives that wavefront's wf_select and pulses its q_rd bit, then captures the selected queue-head word into an output register.
- It hands the word to decode over a valid/ready handshake. It is the read end of the pool; fetch is the write end.

---
 rtl/wq_drain_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/wq_drain_arbiter.sv
// wq_drain_arbiter: read end of the 40-entry wavefront instruction-queue pool.
// Each cycle it round-robin picks one non-empty, eligible wavefront, pops it
// (q_rd/wf_select) and captures the head word into a one-deep register that
// is handed to decode over a valid/ready handshake.
// Optional build macro: WQ_DRAIN_PERF_EN adds perf_grants/perf_stalls counters.
module wq_drain_arbiter #(
  parameter int unsigned NUM_WF = 40,
  parameter int unsigned WFID_W = 6,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_WF-1:0] q_empty,
  input  logic [NUM_WF-1:0] wf_eligible,
  input  logic [DATA_W-1:0] pool_data,
  input  logic              flush_valid,
  input  logic [WFID_W-1:0] flush_wfid,
  output logic [NUM_WF-1:0] q_rd,
  output logic [WFID_W-1:0] wf_select,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [DATA_W-1:0] dec_data,
  output logic [WFID_W-1:0] dec_wfid,
  output logic              busy
`ifdef WQ_DRAIN_PERF_EN
  ,
  output logic [31:0]       perf_grants,
  output logic [31:0]       perf_stalls
`endif
);

  localparam logic [0:0] StEmpty = 1'b0;
  localparam logic [0:0] StFull  = 1'b1;

  localparam int unsigned       LastIdx  = NUM_WF - 1;
  localparam logic [WFID_W-1:0] LastWf   = LastIdx[WFID_W-1:0];
  localparam logic [WFID_W:0]   NumWfExt = NUM_WF[WFID_W:0];
  localparam logic [WFID_W-1:0] OneWf    = {{(WFID_W-1){1'b0}}, 1'b1};

  logic [0:0]        state_q, state_d;
  logic [WFID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic              last_grant_vld_q;
  logic [WFID_W-1:0] last_grant_q;
  logic [WFID_W-1:0] sel_q;
  logic [DATA_W-1:0] data_q, data_d;
  logic [WFID_W-1:0] wfid_q, wfid_d;

  logic [NUM_WF-1:0]   lag_mask;
  logic [NUM_WF-1:0]   flush_mask;
  logic [NUM_WF-1:0]   cand;
  logic [2*NUM_WF-1:0] cand_dbl;
  logic [NUM_WF-1:0]   cand_rot;
  logic                found;
  logic [WFID_W-1:0]   offset;
  logic [WFID_W:0]     idx_sum;
  logic [WFID_W-1:0]   winner;
  logic                can_grant;
  logic                grant;
  logic                flush_hit;

  // Mask out last cycle's grant (q_empty lags a pop) and the flushed wavefront.
  always_comb begin
    lag_mask   = '0;
    flush_mask = '0;
    for (int i = 0; i < NUM_WF; i++) begin
      lag_mask[i]   = last_grant_vld_q && (last_grant_q == i[WFID_W-1:0]);
      flush_mask[i] = flush_valid && (flush_wfid == i[WFID_W-1:0]);
    end
  end

  assign cand = ~q_empty & wf_eligible & ~lag_mask & ~flush_mask;

  // Round-robin search: rotate the doubled candidate vector so rr_ptr lands at
  // bit 0, take the lowest set bit, then map the offset back to a wavefront id.
  always_comb begin
    cand_dbl = {cand, cand};
    cand_rot = cand_dbl[{1'b0, rr_ptr_q} +: NUM_WF];
    found    = 1'b0;
    offset   = '0;
    for (int i = NUM_WF - 1; i >= 0; i--) begin
      if (cand_rot[i]) begin
        found  = 1'b1;
        offset = i[WFID_W-1:0];
      end
    end
    idx_sum = {1'b0, rr_ptr_q} + {1'b0, offset};
    if (idx_sum >= NumWfExt) begin
      idx_sum = idx_sum - NumWfExt;
    end
    winner = idx_sum[WFID_W-1:0];
  end

  assign can_grant = (state_q == StEmpty) || (dec_valid && dec_ready);
  // Gating with rst keeps q_rd low for the whole time reset is asserted,
  // not just from the next edge.
  assign grant     = rst && can_grant && found;

  // One-hot pop strobe for the winner.
  always_comb begin
    q_rd = '0;
    for (int i = 0; i < NUM_WF; i++) begin
      q_rd[i] = grant && (winner == i[WFID_W-1:0]);
    end
  end

  assign wf_select = grant ? winner : sel_q;
  assign dec_valid = (state_q == StFull);
  assign dec_data  = data_q;
  assign dec_wfid  = wfid_q;
  assign busy      = dec_valid || grant;
  assign flush_hit = dec_valid && flush_valid && (flush_wfid == wfid_q);

  // Output register next state: a new grant replaces the word; otherwise a
  // flush of the held wavefront or a decode accept empties it.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    wfid_d   = wfid_q;
    rr_ptr_d = rr_ptr_q;
    if (grant) begin
      state_d  = StFull;
      data_d   = pool_data;
      wfid_d   = winner;
      rr_ptr_d = (winner == LastWf) ? '0 : winner + OneWf;
    end else if (flush_hit || (dec_valid && dec_ready)) begin
      state_d = StEmpty;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= StEmpty;
      rr_ptr_q         <= '0;
      last_grant_vld_q <= 1'b0;
      last_grant_q     <= '0;
      sel_q            <= '0;
      data_q           <= '0;
      wfid_q           <= '0;
    end else begin
      state_q          <= state_d;
      rr_ptr_q         <= rr_ptr_d;
      last_grant_vld_q <= grant;
      if (grant) begin
        last_grant_q <= winner;
      end
      sel_q            <= wf_select;
      data_q           <= data_d;
      wfid_q           <= wfid_d;
    end
  end

`ifdef WQ_DRAIN_PERF_EN
  logic [31:0] perf_grants_q;
  logic [31:0] perf_stalls_q;

  // Free-running wrap-around event counters; observation only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_grants_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      if (grant) begin
        perf_grants_q <= perf_grants_q + 32'd1;
      end
      if (dec_valid && !dec_ready) begin
        perf_stalls_q <= perf_stalls_q + 32'd1;
      end
    end
  end

  assign perf_grants = perf_grants_q;
  assign perf_stalls = perf_stalls_q;
`endif

endmodule
